// File: rtl/mips_isa_pkg.sv
// ============================================================================
// Module      : mips_isa_pkg
// Description : Shared MIPS field layout, opcode constants and loader states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam int OP_HI     = 31;
    localparam int OP_LO     = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2,
        ST_FULL = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } instr_fmt_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    // Anything that is neither R-type nor a jump is treated as I-type.
    function automatic instr_fmt_t opcode_format(input logic [5:0] op);
        instr_fmt_t fmt;
        if (op == OP_RTYPE) begin
            fmt = FMT_R;
        end else if ((op == OP_J) || (op == OP_JAL)) begin
            fmt = FMT_J;
        end else begin
            fmt = FMT_I;
        end
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_instr_pack.sv
// ============================================================================
// Module      : mips_instr_pack
// Description : Combinational encoder from MIPS instruction fields to a word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] instr
);

    logic [31:0] w_word;

    always_comb begin
        w_word                = '0;
        w_word[OP_HI:OP_LO]   = opcode;
        case (opcode_format(opcode))
            FMT_R: begin
                w_word[RS_HI:RS_LO]       = rs;
                w_word[RT_HI:RT_LO]       = rt;
                w_word[RD_HI:RD_LO]       = rd;
                w_word[SHAMT_HI:SHAMT_LO] = shamt;
                w_word[FUNCT_HI:FUNCT_LO] = funct;
            end
            FMT_J: begin
                w_word[TARGET_HI:TARGET_LO] = target;
            end
            default: begin
                w_word[RS_HI:RS_LO]   = rs;
                w_word[RT_HI:RT_LO]   = rt;
                w_word[IMM_HI:IMM_LO] = imm;
            end
        endcase
    end

    assign instr = w_word;

endmodule

`default_nettype wire

// File: rtl/mips_instr_loader.sv
// ============================================================================
// Module      : mips_instr_loader
// Description : Accepts instruction field bundles, encodes them and writes the
//               words sequentially into program memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_instr_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done
);

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    loader_state_t     r_state;
    instr_fields_t     r_fields;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_done;

    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_count_next;
    logic              w_accept;

    // Gated by reset and clear so nothing can be taken while either is active.
    assign in_ready     = reset & ~clear & load_en & (r_state == ST_IDLE);
    assign w_accept     = in_valid & in_ready;
    assign w_count_next = r_count + c_cnt_one;

    mips_instr_pack u_pack (
        .opcode (r_fields.opcode),
        .rs     (r_fields.rs),
        .rt     (r_fields.rt),
        .rd     (r_fields.rd),
        .shamt  (r_fields.shamt),
        .funct  (r_fields.funct),
        .imm    (r_fields.imm),
        .target (r_fields.target),
        .instr  (w_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_fields <= '0;
            r_mem_we <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state  <= ST_IDLE;
                r_mem_we <= 1'b0;
                r_addr   <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_fields.opcode <= opcode;
                            r_fields.rs     <= rs;
                            r_fields.rt     <= rt;
                            r_fields.rd     <= rd;
                            r_fields.shamt  <= shamt;
                            r_fields.funct  <= funct;
                            r_fields.imm    <= imm;
                            r_fields.target <= target;
                            r_state         <= ST_ENC;
                        end
                    end
                    ST_ENC: begin
                        r_wdata  <= w_word;
                        r_mem_we <= 1'b1;
                        r_state  <= ST_WR;
                    end
                    ST_WR: begin
                        // Address and data stay frozen until memory takes them.
                        if (mem_ready) begin
                            r_mem_we <= 1'b0;
                            r_addr   <= r_addr + c_addr_one;
                            r_count  <= w_count_next;
                            r_done   <= 1'b1;
                            if (w_count_next == c_depth) begin
                                r_full  <= 1'b1;
                                r_state <= ST_FULL;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_FULL: begin
                        r_mem_we <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = r_full;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_loader.sv
// ============================================================================
// Module      : tb_mips_instr_loader
// Description : Scoreboard bench for the instruction loader (4-word memory).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_instr_loader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              load_en = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [5:0]        opcode = '0;
    logic [4:0]        rs = '0;
    logic [4:0]        rt = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        shamt = '0;
    logic [5:0]        funct = '0;
    logic [15:0]       imm = '0;
    logic [25:0]       target = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready = 1'b1;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } sb_t;

    sb_t               sb[$];
    sb_t               mon_e;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                n_checks = 0;
    int                n_errors = 0;

    mips_instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .target    (target),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count),
        .full      (full),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write the memory actually takes must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset && mem_we && mem_ready && !clear) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_addr", 64'(mem_addr), 64'(mon_e.addr));
                chk("sb_data", 64'(mem_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
                        input logic [15:0] f_imm, input logic [25:0] f_tgt,
                        input logic [31:0] word, input bit push);
        int t = 0;
        opcode = op; rs = f_rs; rt = f_rt; rd = f_rd;
        shamt = f_sh; funct = f_fn; imm = f_imm; target = f_tgt;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        if (push) begin
            sb.push_back('{addr: exp_addr, data: word});
            exp_addr = exp_addr + 1'b1;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        @(negedge clock);
        while (!done && t < 30) begin
            @(negedge clock);
            t++;
        end
        chk(tag, 64'(done), 64'd1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with load_en high to prove in_ready is held low.
        @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // R-type add with the exact latency profile.
        send(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h3ABCDEF, 32'h00221820, 1'b1);
        @(negedge clock);
        chk("enc_mem_we", 64'(mem_we), 64'd0);
        @(negedge clock);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_in_ready", 64'(in_ready), 64'd0);
        chk("wr_addr0", 64'(mem_addr), 64'd0);
        @(negedge clock);
        chk("we_one_cycle", 64'(mem_we), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        chk("count_1", 64'(count), 64'd1);
        chk("in_ready_n3", 64'(in_ready), 64'd1);
        @(negedge clock);
        chk("done_clear", 64'(done), 64'd0);
        tick();

        // I-type addi with garbage in the R-type-only fields.
        send(6'h08, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h2022FFFF, 1'b1);
        wait_done("done_itype");
        chk("count_2", 64'(count), 64'd2);

        // J-type with a stray rs value.
        send(6'h02, 5'd31, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000010, 32'h08000010, 1'b1);
        wait_done("done_j");
        chk("count_3", 64'(count), 64'd3);

        // JAL under three cycles of back-pressure; this is the final word.
        mem_ready = 1'b0;
        send(6'h03, 5'd31, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000010, 32'h0C000010, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_mem_we", 64'(mem_we), 64'd1);
            chk("bp_addr", 64'(mem_addr), 64'd3);
            chk("bp_wdata", 64'(mem_wdata), 64'h0C000010);
            chk("bp_count", 64'(count), 64'd3);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        tick();
        mem_ready = 1'b1;
        wait_done("done_jal");

        // Full: address wraps, count reads DEPTH, further bundles ignored.
        @(negedge clock);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_count", 64'(count), 64'd4);
        chk("full_wrap_addr", 64'(mem_addr), 64'd0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("full_ignore_we", 64'(mem_we), 64'd0);
        end
        tick();
        in_valid = 1'b0;
        chk("full_hold_count", 64'(count), 64'd4);

        // Clear pulse with a bundle presented in the same cycle.
        clear = 1'b1;
        in_valid = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        exp_addr = '0;
        @(negedge clock);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_addr", 64'(mem_addr), 64'd0);
        chk("clr_full", 64'(full), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_no_accept_1", 64'(mem_we), 64'd0);
        @(negedge clock);
        chk("clr_no_accept_2", 64'(mem_we), 64'd0);
        tick();

        // Clear while stalled in WR abandons the write.
        mem_ready = 1'b0;
        send(6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'h0, 26'h0, 32'h0, 1'b0);
        tick();
        @(negedge clock);
        chk("cwr_mem_we", 64'(mem_we), 64'd1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clock);
        chk("cwr_mem_we_drop", 64'(mem_we), 64'd0);
        chk("cwr_count", 64'(count), 64'd0);
        chk("cwr_addr", 64'(mem_addr), 64'd0);
        chk("cwr_done", 64'(done), 64'd0);
        chk("cwr_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Asynchronous reset between edges while in WR.
        send(6'h23, 5'd7, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0040, 26'h0, 32'h0, 1'b0);
        tick();
        @(negedge clock);
        chk("ar_mem_we_before", 64'(mem_we), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mem_we", 64'(mem_we), 64'd0);
        chk("ar_wdata", 64'(mem_wdata), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        exp_addr = '0;
        tick();
        send(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h00221820, 1'b1);
        wait_done("done_post_reset");
        chk("post_reset_count", 64'(count), 64'd1);
        chk("post_reset_addr", 64'(mem_addr), 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_instr_loader.md
Name: mips_instr_loader

Overview:
- Assembles a MIPS instruction word from individual fields (opcode, rs, rt, rd, shamt, funct, imm, target) and writes it sequentially into the program memory.
- It is the write side of the program memory and the encoder counterpart of the instruction-field splitter.
- It feeds the program memory before the CPU FSM starts fetching.
- It provides a valid/ready field-input handshake, an auto-incrementing write address, memory write back-pressure, and a full flag.

Parameters:
- ADDR_W, 5, program memory address width.
- DEPTH, 32, number of words loadable before full; must be <= 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  permits acceptance of new fields.
- clear  in  1  synchronous restart: address and count return to 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- opcode  in  6  instruction opcode.
- rs  in  5  source register.
- rt  in  5  target register.
- rd  in  5  destination register (R-type).
- shamt  in  5  shift amount (R-type).
- funct  in  6  function code (R-type).
- imm  in  16  immediate (I-type).
- target  in  26  jump target (J-type).
- mem_we  out  1  program memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepted the write this cycle.
- count  out  ADDR_W+1  words written so far.
- full  out  1  DEPTH words written.
- done  out  1  one-cycle pulse per completed write.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, count, full, done. Captured fields are cleared.
- Format is selected by opcode:
  - opcode=0 is R-type: {opcode, rs, rt, rd, shamt, funct}.
  - opcode=2 or 3 is J-type: {opcode, target}.
  - Any other opcode is I-type: {opcode, rs, rt, imm}.
  - Fields not used by the selected format are ignored.
- States:
  - IDLE: in_ready = load_en. On in_valid & in_ready, register all fields and go to ENC.
  - ENC: one cycle. Register the encoded word into mem_wdata, then go to WR. in_ready=0.
  - WR: mem_we=1. mem_addr and mem_wdata are held stable until mem_ready=1. On the cycle mem_ready=1 is sampled:
    - mem_addr and count increment and done pulses the following cycle.
    - If the new count equals DEPTH, go to FULL; otherwise go to IDLE.
  - FULL: full=1, in_ready=0, mem_we=0. Stay here until clear.
- Latency with mem_ready tied high:
  - Bundle accepted at edge N.
  - mem_we is high during cycle N+2.
  - Earliest next acceptance is at edge N+3, giving a throughput of 1 word per 3 cycles.
- clear has priority over everything in every state:
  - Next state is IDLE; mem_addr=0, count=0, full=0, mem_we drops.
  - A write pending in WR is abandoned and not counted.
  - A bundle presented in the same cycle as clear is not accepted.
- If load_en drops during ENC or WR, the current word still completes. Only new acceptance is blocked.
- in_valid while in_ready=0 is ignored; the source must hold the bundle.
- Wrap: when DEPTH = 2**ADDR_W, mem_addr wraps to 0 on the final write, while count reads DEPTH and full=1.
- An asynchronous reset mid-write returns immediately to the reset values; no partial state survives.
- done is registered and is never asserted together with reset or clear.

Decomposition:
- Shared package mips_isa_pkg:
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03.
  - field bit positions (OP 31:26, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNCT 5:0, IMM 15:0, TARGET 25:0).
  - loader state enum IDLE/ENC/WR/FULL.
- The splitter reuses the same field constants.
- One combinational sub-module, mips_instr_pack: fields in, 32-bit word out. It is separately testable and later reused by the CPU testbench.

Test Plan:
- R-type add: opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, mem_ready=1 -> mem_wdata=0x00221820 at mem_addr 0, mem_we high exactly 1 cycle (N+2), done pulse, count=1.
- I-type addi: opcode=0x08, rs=1, rt=2, imm=0xFFFF with rd/shamt/funct garbage -> mem_wdata=0x2022FFFF at addr 1.
- J-type: opcode=2, target=0x0000010 with rs=31 -> mem_wdata=0x08000010. For opcode=3 with the same target -> 0x0C000010.
- Back-pressure: mem_ready low for 3 cycles in WR -> mem_we, mem_addr and mem_wdata stable all 3 cycles, count increments only after mem_ready=1, in_ready stays 0.
- Full/clear with DEPTH=4:
  - Load 4 words -> full=1, in_ready=0, a 5th in_valid is ignored.
  - Pulse clear -> count=0, mem_addr=0, full=0, in_ready=1.
  - clear during WR -> write abandoned, count unchanged at 0.
- Async reset: assert reset=0 mid-WR (between clock edges) -> mem_we and all outputs go to 0 immediately. After release, the first bundle is written to addr 0.
